// File: rtl/riscv_trace_pkg.sv
// Shared types for the RISC-V commit-trace buffer: FSM state encoding and fixed field widths.
// TRACE_TIMESTAMP_EN adds a per-entry cycle timestamp of TRACE_TS_W bits.
package riscv_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam int INSTR_W    = 32;
  localparam int RD_W       = 5;
  localparam int TRACE_TS_W = 32;

  typedef logic [TRACE_TS_W-1:0] trace_ts_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x W, one write port and one registered read port.
module trace_ram #(
  parameter  int DEPTH = 64,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // NOTE: no reset on the array or read register so this maps onto block RAM; validity is tracked outside.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture: circular buffer with PC-match/forced trigger, post-trigger window, oldest-first readout.
// Define TRACE_TIMESTAMP_EN to store a free-running cycle count per entry and expose rd_time.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               resetPC,
  input  logic               commit_valid,
  input  logic [XLEN-1:0]    commit_pc,
  input  logic [INSTR_W-1:0] commit_instr,
  input  logic [RD_W-1:0]    commit_rd,
  input  logic [XLEN-1:0]    commit_wdata,
  input  logic               commit_regwen,
  input  logic               commit_memrw,
  input  logic               trig_arm,
  input  logic               trig_force,
  input  logic               trig_pc_en,
  input  logic [XLEN-1:0]    trig_pc,
  input  logic [AW-1:0]      post_count,
  input  logic               rd_en,
  output logic               rd_valid,
  output logic [XLEN-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [RD_W-1:0]    rd_rd,
  output logic [XLEN-1:0]    rd_wdata,
  output logic               rd_regwen,
  output logic               rd_memrw,
  output logic               rd_last,
  output logic [1:0]         state,
  output logic [AW:0]        entries
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [TRACE_TS_W-1:0] rd_time
`endif
);

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    trace_ts_t          ts;
`endif
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [RD_W-1:0]    rd;
    logic [XLEN-1:0]    wdata;
    logic               regwen;
    logic               memrw;
  } entry_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  trace_state_e  r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_post_cnt;
  logic [AW:0]   r_entries;
  logic          r_rd_valid;
  logic          r_rd_last;

  logic          w_trig;
  logic          w_write;
  logic          w_pop;
  logic [AW-1:0] w_rd_ptr;
  entry_t        w_wr_entry;
  entry_t        w_rd_entry;
  entry_t        w_rd_out;

  assign w_trig  = trig_force | (commit_valid & trig_pc_en & (commit_pc == trig_pc));
  assign w_write = ~trig_arm & commit_valid & ((r_state == ST_ARMED) | (r_state == ST_POST));
  assign w_pop   = ~trig_arm & rd_en & (r_state == ST_DONE) & (r_entries != '0);
  // Oldest entry sits `entries` slots behind the write pointer; popping advances it implicitly.
  assign w_rd_ptr = r_wr_ptr - r_entries[AW-1:0];

`ifdef TRACE_TIMESTAMP_EN
  trace_ts_t r_time;

  always_ff @(posedge CLK or negedge resetPC) begin
    if (!resetPC) r_time <= '0;
    else          r_time <= r_time + 1'b1;
  end

  assign w_wr_entry.ts = r_time;
  assign rd_time       = w_rd_out.ts;
`endif

  assign w_wr_entry.pc     = commit_pc;
  assign w_wr_entry.instr  = commit_instr;
  assign w_wr_entry.rd     = commit_rd;
  assign w_wr_entry.wdata  = commit_wdata;
  assign w_wr_entry.regwen = commit_regwen;
  assign w_wr_entry.memrw  = commit_memrw;

  trace_ram #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_ram (
    .clk     (CLK),
    .i_we    (w_write),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_re    (w_pop),
    .i_raddr (w_rd_ptr),
    .o_rdata (w_rd_entry)
  );

  // NOTE: every register here uses <= so all updates see the same pre-edge values regardless of order.
  always_ff @(posedge CLK or negedge resetPC) begin
    if (!resetPC) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_post_cnt <= '0;
      r_entries  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      r_rd_last  <= w_pop && (r_entries == (AW+1)'(1));
      if (trig_arm) begin
        r_state   <= ST_ARMED;
        r_wr_ptr  <= '0;
        r_entries <= '0;
      end else begin
        if (w_write) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
          if (r_entries != FULL) r_entries <= r_entries + (AW+1)'(1);
        end
        if (w_pop) r_entries <= r_entries - (AW+1)'(1);
        case (r_state)
          ST_ARMED: begin
            if (w_trig) begin
              if (post_count == '0) begin
                r_state <= ST_DONE;
              end else begin
                r_post_cnt <= post_count;
                r_state    <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (commit_valid) begin
              r_post_cnt <= r_post_cnt - AW'(1);
              if (r_post_cnt == AW'(1)) r_state <= ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read fields are forced to zero whenever no popped entry is being presented.
  assign w_rd_out = r_rd_valid ? w_rd_entry : '0;

  assign rd_valid  = r_rd_valid;
  assign rd_pc     = w_rd_out.pc;
  assign rd_instr  = w_rd_out.instr;
  assign rd_rd     = w_rd_out.rd;
  assign rd_wdata  = w_rd_out.wdata;
  assign rd_regwen = w_rd_out.regwen;
  assign rd_memrw  = w_rd_out.memrw;
  assign rd_last   = r_rd_last;
  assign state     = r_state;
  assign entries   = r_entries;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Self-checking bench for riscv_trace_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_riscv_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic            CLK = 1'b0;
  logic            resetPC = 1'b0;
  logic            commit_valid = 1'b0;
  logic [31:0]     commit_pc = '0, commit_instr = '0, commit_wdata = '0, trig_pc = '0;
  logic [4:0]      commit_rd = '0;
  logic            commit_regwen = 1'b0, commit_memrw = 1'b0;
  logic            trig_arm = 1'b0, trig_force = 1'b0, trig_pc_en = 1'b0, rd_en = 1'b0;
  logic [AW-1:0]   post_count = '0;
  logic            rd_valid, rd_regwen, rd_memrw, rd_last;
  logic [31:0]     rd_pc, rd_instr, rd_wdata;
  logic [4:0]      rd_rd;
  logic [1:0]      state;
  logic [AW:0]     entries;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]     rd_time;
  logic [31:0]     t_log[$];
`endif

  riscv_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .resetPC(resetPC),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_rd(commit_rd), .commit_wdata(commit_wdata), .commit_regwen(commit_regwen),
    .commit_memrw(commit_memrw), .trig_arm(trig_arm), .trig_force(trig_force),
    .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .post_count(post_count), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_rd(rd_rd),
    .rd_wdata(rd_wdata), .rd_regwen(rd_regwen), .rd_memrw(rd_memrw), .rd_last(rd_last),
    .state(state), .entries(entries)
`ifdef TRACE_TIMESTAMP_EN
    , .rd_time(rd_time)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the buffer is a queue of records, oldest at the front.
  typedef struct {
    logic [31:0] pc, instr, wdata;
    logic [4:0]  rd;
    logic        regwen, memrw;
  } ent_t;

  ent_t        m_q[$];
  int          m_state = 0;
  int          m_left  = 0;
  logic [31:0] rd_log[$];
  logic [31:0] last_flag_pc;

  task automatic push_commit();
    m_q.push_back('{commit_pc, commit_instr, commit_wdata, commit_rd, commit_regwen, commit_memrw});
    if (m_q.size() > DEPTH) m_q.delete(0);
  endtask

  // Advance one clock, update the model from the inputs the DUT sampled, then compare.
  task automatic step();
    ent_t e;
    bit   ev = 0, el = 0, hit;
    @(posedge CLK);
    if (!resetPC) begin
      m_q.delete(); m_state = 0;
    end else if (trig_arm) begin
      m_q.delete(); m_state = 1;
    end else begin
      case (m_state)
        1: begin
          hit = trig_force || (commit_valid && trig_pc_en && commit_pc == trig_pc);
          if (commit_valid) push_commit();
          if (hit) begin
            if (post_count == 0) m_state = 3;
            else begin m_left = int'(post_count); m_state = 2; end
          end
        end
        2: if (commit_valid) begin
          push_commit(); m_left--;
          if (m_left == 0) m_state = 3;
        end
        3: if (rd_en && m_q.size() > 0) begin
          e = m_q.pop_front(); ev = 1; el = (m_q.size() == 0);
        end
        default: ;
      endcase
    end
    #1;
    check("state", 64'(state), 64'(m_state));
    check("entries", 64'(entries), 64'(m_q.size()));
    check("rd_valid", 64'(rd_valid), 64'(ev));
    if (ev) begin
      check("rd_pc", 64'(rd_pc), 64'(e.pc));
      check("rd_instr", 64'(rd_instr), 64'(e.instr));
      check("rd_wdata", 64'(rd_wdata), 64'(e.wdata));
      check("rd_flags", 64'({rd_rd, rd_regwen, rd_memrw}), 64'({e.rd, e.regwen, e.memrw}));
      check("rd_last", 64'(rd_last), 64'(el));
      rd_log.push_back(rd_pc);
      if (el) last_flag_pc = rd_pc;
`ifdef TRACE_TIMESTAMP_EN
      t_log.push_back(rd_time);
`endif
    end
  endtask

  task automatic commit(input logic [31:0] pc);
    commit_valid = 1'b1; commit_pc = pc;
    commit_instr = $urandom; commit_wdata = $urandom; commit_rd = 5'($urandom);
    commit_regwen = 1'($urandom); commit_memrw = 1'($urandom);
    step();
    commit_valid = 1'b0;
  endtask

  task automatic arm();
    trig_arm = 1'b1; step(); trig_arm = 1'b0;
  endtask

  task automatic force_trig(input int post);
    trig_force = 1'b1; post_count = AW'(post); step(); trig_force = 1'b0;
  endtask

  // Pop until the model is empty, then one more read that must be ignored.
  task automatic drain();
    rd_log.delete();
`ifdef TRACE_TIMESTAMP_EN
    t_log.delete();
`endif
    last_flag_pc = 32'hdead_beef;
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH + 2 && m_q.size() > 0; i++) step();
    check("drain_done", 64'(m_q.size()), 64'd0);
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_state", 64'(state), 64'd0);
    check("rst_entries", 64'(entries), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_pc", 64'(rd_pc), 64'd0);
    @(negedge CLK); resetPC = 1'b1;

    commit(32'h500);                      // ignored in IDLE

    // 10 commits every third cycle, forced trigger, full readout.
    arm();
    for (int i = 0; i < 10; i++) begin commit(32'(4 * i)); step(); step(); end
    force_trig(0);
    check("t1_state", 64'(state), 64'd3);
    check("t1_entries", 64'(entries), 64'd10);
    drain();
    check("t1_count", 64'(rd_log.size()), 64'd10);
    check("t1_first_pc", 64'(rd_log[0]), 64'h0);
    check("t1_last_pc", 64'(last_flag_pc), 64'd36);
`ifdef TRACE_TIMESTAMP_EN
    for (int i = 1; i < t_log.size(); i++) check("t1_ts_delta", 64'(t_log[i] - t_log[i-1]), 64'd3);
`endif

    // 100 commits, PC-match on commit 99 with the buffer wrapped.
    arm();
    trig_pc_en = 1'b1; trig_pc = 32'h18C; post_count = '0;
    for (int i = 0; i < 100; i++) commit(32'(4 * i));
    check("t2_state", 64'(state), 64'd3);
    check("t2_entries", 64'(entries), 64'd64);
    drain();
    check("t2_first_pc", 64'(rd_log[0]), 64'h90);

    // PC-match at 0x40 with a 5-commit post window; later commits must not be stored.
    arm();
    trig_pc = 32'h40; post_count = AW'(5);
    for (int i = 0; i < 30; i++) commit(32'(4 * i));
    check("t3_entries", 64'(entries), 64'd22);
    drain();
    check("t3_last_pc", 64'(last_flag_pc), 64'h54);
    trig_pc_en = 1'b0;

    // Arm and commit in the same cycle: that commit is dropped.
    commit_valid = 1'b1; commit_pc = 32'h100; trig_arm = 1'b1;
    step();
    trig_arm = 1'b0; commit_valid = 1'b0;
    check("t4_entries0", 64'(entries), 64'd0);
    commit(32'h104);
    check("t4_entries1", 64'(entries), 64'd1);
    force_trig(0);
    drain();
    check("t4_first_pc", 64'(rd_log[0]), 64'h104);

    // Asynchronous reset while in POST.
    arm();
    commit(32'h0); commit(32'h4);
    force_trig(10);
    commit(32'h8); commit(32'hC);
    check("t5_post", 64'(state), 64'd2);
    #3 resetPC = 1'b0;
    #1;
    check("t5_rst_state", 64'(state), 64'd0);
    check("t5_rst_entries", 64'(entries), 64'd0);
    check("t5_rst_rd_valid", 64'(rd_valid), 64'd0);
    m_q.delete(); m_state = 0;
    step();
    resetPC = 1'b1;

    // Randomized traffic with PCs from a small pool so matches occur.
    for (int n = 0; n < 3000; n++) begin
      commit_valid  = ($urandom_range(0, 3) != 0);
      commit_pc     = 32'(4 * $urandom_range(0, 15));
      commit_instr  = $urandom; commit_wdata = $urandom; commit_rd = 5'($urandom);
      commit_regwen = 1'($urandom); commit_memrw = 1'($urandom);
      trig_arm      = ($urandom_range(0, 49) == 0);
      trig_force    = ($urandom_range(0, 39) == 0);
      trig_pc_en    = 1'($urandom);
      trig_pc       = 32'(4 * $urandom_range(0, 15));
      post_count    = AW'($urandom_range(0, 7));
      rd_en         = 1'($urandom);
      step();
    end
    commit_valid = 1'b0; trig_arm = 1'b0; trig_force = 1'b0; trig_pc_en = 1'b0;
    if (m_state == 3) drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
